lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store initiator for the memory stage of the rv32i pipeline. It drives the word-addressed, byte-masked data RAM port (request, w_en, address, masking, write_data, read_data).
- Stores: generates byte masks and replicates store data into the selected byte lanes.
- Loads: extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it.
- Sequences each access with a small FSM and reports done, busy and err to the pipeline.

Parameters:
ADDR_WIDTH, 8, word-address width of the RAM port (RAM holds 2^ADDR_WIDTH 32-bit words)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
valid  input  1  memory-stage op present this cycle
is_load  input  1  op is a load (LB/LH/LW/LBU/LHU)
is_store  input  1  op is a store (SB/SH/SW)
funct3  input  3  RV32I funct3 of the op
addr  input  32  byte address from the ALU
store_data  input  32  rs2 value
request  output  1  RAM request strobe
w_en  output  1  RAM write enable
address  output  ADDR_WIDTH  RAM word address, equal to addr[ADDR_WIDTH+1:2]
masking  output  4  RAM byte-lane write mask
write_data  output  32  lane-aligned store data
read_data  input  32  RAM read word, valid in the cycle after a read request
load_data  output  32  extended load result
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, coincident with done, for a rejected access
busy  output  1  high while state is not IDLE; the pipeline holds its op while busy

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including request, w_en, address, masking, write_data, load_data, done, err and busy. An access in flight is abandoned and request drops immediately.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP, FIN.
- IDLE: on valid & (is_load | is_store), capture funct3, addr and store_data, then:
  - illegal access → FIN with err;
  - otherwise → REQ.
  - valid with neither is_load nor is_store is ignored. If both are set, store wins.
- Illegal access:
  - halfword (funct3[1:0]=01) with addr[0]=1;
  - word (funct3[1:0]=10) with addr[1:0]≠0;
  - load funct3 ∈ {011,110,111};
  - store funct3[2]=1 or funct3=011.
  - No request is issued.
- REQ: request=1 for exactly one cycle. address=addr[ADDR_WIDTH+1:2].
  - Store: w_en=1.
    - SB: masking=1<<addr[1:0], write_data={4{sd[7:0]}}.
    - SH: masking=addr[1]?1100:0011, write_data={2{sd[15:0]}}.
    - SW: masking=1111, write_data=sd.
    - Next state FIN.
  - Load: w_en=0, masking=0000. Next state RESP.
- RESP: sample read_data.
  - Byte select = addr[1:0]; halfword select = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into load_data. Next state FIN.
- FIN: done=1 for one cycle (err=1 if the access was rejected). Next state IDLE.
- load_data holds its last value until the next load completes. Stores and errors do not change it.
- Latency, counted from the acceptance edge (cycle 0):
  - store: request in cycle 1, done in cycle 2;
  - load: request in cycle 1, read_data in cycle 2, done with load_data in cycle 3;
  - error: done+err in cycle 1.
- busy=1 from cycle 1 until done, inclusive. valid is ignored while busy; there is no queuing.
- Back-to-back: a new op may be accepted in the IDLE cycle following FIN, giving a minimum 3-cycle store or 4-cycle load repeat.
- Address wrap: bits of addr above ADDR_WIDTH+1 are ignored; the address wraps modulo RAM size, unless the optional feature is compiled in.
- request is never 1 outside REQ. w_en is never 1 without request.

Optional Feature:
LSU_BOUNDS_CHECK_EN
- Defined: in IDLE, an access with addr[31:ADDR_WIDTH+2]≠0 is illegal. It goes to FIN with err=1 and issues no request.
- Undefined: upper address bits are silently dropped, giving wrap-around.

Test Plan:
- Reset, then SW addr=0x10, sd=0xDEADBEEF → cycle 1: request=1, w_en=1, address=0x04, masking=1111, write_data=0xDEADBEEF; cycle 2: done=1, err=0.
- SB addr=0x13, sd=0x000000A5 → masking=1000, write_data=0xA5A5A5A5. A following LW addr=0x10 returns 0xA5ADBEEF with done in cycle 3.
- RAM word 0x80F0_7F01 at word address 0x05:
  - LB addr=0x17 → load_data=0xFFFFFF80;
  - LBU addr=0x17 → 0x00000080;
  - LH addr=0x14 → 0x00007F01;
  - LHU addr=0x16 → 0x000080F0.
- LW addr=0x22 and SH addr=0x21 → no request; done=1, err=1 in cycle 1; load_data unchanged.
- Assert rst during the REQ cycle of a store → request/w_en drop immediately; state IDLE, busy=0; RAM is not written at the next edge.
- With LSU_BOUNDS_CHECK_EN, LW addr=0x400 → err=1, no request. Without it → request with address=0x00.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for the rv32i memory stage.
// Drives a word-addressed, byte-masked RAM port; sequences each access
// through IDLE -> REQ -> (RESP) -> FIN and reports done/err/busy.
// Optional: LSU_BOUNDS_CHECK_EN rejects byte addresses beyond the RAM
// instead of letting them wrap modulo the RAM size.

// One byte lane of the store path: lane enable and the byte it carries.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // funct3[1:0]: 00 byte, 01 half, 10 word
  input  logic [1:0]  boff,   // byte offset within the word
  input  logic [31:0] sd,
  output logic        mask,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LID = LANE[1:0];

  // Lane select and data replication for SB/SH/SW
  always_comb begin
    mask  = 1'b0;
    wbyte = sd[7:0];
    case (size)
      2'b00: mask = (boff == LID);
      2'b01: begin
        mask  = (boff[1] == LID[1]);
        wbyte = LID[0] ? sd[15:8] : sd[7:0];
      end
      default: begin
        mask  = 1'b1;
        wbyte = sd[8*LANE +: 8];
      end
    endcase
  end
endmodule

module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  request,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            masking,
  output logic [31:0]           write_data,
  input  logic [31:0]           read_data,
  output logic [31:0]           load_data,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;

  state_t     state;
  logic [2:0] f3_q;
  logic [1:0] boff_q;

  // Store wins when both op flags are set
  logic st_acc, ld_acc, illegal;
  assign st_acc = valid & is_store;
  assign ld_acc = valid & is_load & ~is_store;

  // Alignment and encoding checks on the incoming op
  always_comb begin
    illegal = 1'b0;
    if (funct3[1:0] == 2'b01 && addr[0])            illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
    if (ld_acc && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    if (st_acc && (funct3[2] || funct3 == 3'b011))  illegal = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if (|addr[31:ADDR_WIDTH+2])                     illegal = 1'b1;
`endif
  end

  logic [NUM_LANES-1:0]      lane_mask;
  logic [NUM_LANES-1:0][7:0] lane_wd;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lsu_lane #(.LANE(g)) u_lane (
        .size (funct3[1:0]),
        .boff (addr[1:0]),
        .sd   (store_data),
        .mask (lane_mask[g]),
        .wbyte(lane_wd[g])
      );
    end
  endgenerate

  // Load extraction and extension from the returned word
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  always_comb begin
    ld_byte = read_data[8*boff_q +: 8];
    ld_half = boff_q[1] ? read_data[31:16] : read_data[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = read_data;
    endcase
  end

  // Access sequencer; every port output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      f3_q       <= '0;
      boff_q     <= '0;
      request    <= 1'b0;
      w_en       <= 1'b0;
      address    <= '0;
      masking    <= '0;
      write_data <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (st_acc | ld_acc) begin
          f3_q   <= funct3;
          boff_q <= addr[1:0];
          busy   <= 1'b1;
          if (illegal) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state   <= REQ;
            request <= 1'b1;
            w_en    <= st_acc;
            address <= addr[ADDR_WIDTH+1:2];
            masking <= st_acc ? lane_mask : 4'b0000;
            if (st_acc) write_data <= lane_wd;
          end
        end
        // w_en doubles as the store flag for the REQ cycle
        REQ: begin
          request <= 1'b0;
          w_en    <= 1'b0;
          if (w_en) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          load_data <= ld_ext;
          done      <= 1'b1;
          state     <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
